imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 30, word-address width of both requesters and the memory.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter STARVE_LIMIT, default 4, range 1..7; consecutive lost arbitrations before port 1 is promoted.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req0_valid  input  1  port 0 (CPU fetch) read request.
REQ-007 req0_addr  input  ADDR_W  port 0 word address.
REQ-008 req0_ready  output  1  port 0 request accepted this cycle.
REQ-009 rsp0_valid  output  1  rsp0_data carries port 0 read data.
REQ-010 rsp0_data  output  DATA_W  port 0 read data.
REQ-011 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same as port 0, for port 1 (loader/debug).
REQ-012 mem_addr  output  ADDR_W  address to the instruction memory; the memory registers it and returns data one cycle later.
REQ-013 mem_inst  input  DATA_W  instruction memory read data.

Function
REQ-014 At most one grant per cycle; grant = reqN_valid & reqN_ready; reqN_ready is combinational and high only for the winner.
REQ-015 Arbitration: port 0 wins when req0_valid, unless port 1 is promoted (REQ-021); port 1 wins when req1_valid and port 0 does not win.
REQ-016 Grant cycle: mem_addr = winner's address, combinationally; register addr_hold loads it.
REQ-017 No grant: mem_addr = addr_hold, so the memory re-reads the last granted address.
REQ-018 Latency: grant in cycle N -> rspN_valid high in cycle N+1 only, via registers rsp_pend and rsp_id.
REQ-019 rsp0_data = rsp1_data = mem_inst at all times; only rspN_valid qualifies the data.
REQ-020 Throughput: back-to-back grants every cycle, including alternating ports; no bubbles.
REQ-021 Starvation counter (3 bits): increments when req1_valid and port 0 wins; clears on port 1 grant or when req1_valid is low; saturates at STARVE_LIMIT; promoted when counter == STARVE_LIMIT.
REQ-022 A request whose valid drops before grant is dropped without state change; addresses need not be held stable by requesters across cycles.
REQ-023 No requests: both ready low, no rsp_valid the following cycle, mem_addr = addr_hold.

Reset
REQ-024 While rst is high: req0_ready = req1_ready = 0 and no grant occurs.
REQ-025 On rst: rsp_pend = 0, rsp_id = 0, addr_hold = 0, starvation counter = 0; therefore rsp0_valid = rsp1_valid = 0 and mem_addr = 0.
REQ-026 A grant issued in the cycle before rst asserts yields no response; the pending response is discarded.
REQ-027 First grant is possible in the first cycle with rst low.

Configuration
REQ-028 Macro IMEM_ARB_STARVE_EN defined: starvation counter and promotion per REQ-021 are present.
REQ-029 Macro IMEM_ARB_STARVE_EN undefined: counter is removed; pure fixed priority, port 0 always wins, port 1 may starve indefinitely; STARVE_LIMIT is ignored.

Verification
REQ-030 req0 alone, addr 0x0,0x1,0x2 on consecutive cycles -> req0_ready high each cycle; rsp0_valid high on the next three cycles; rsp0_data from the memory = 0x3c081000, 0x350800b0, 0x3c091000.
REQ-031 req0 and req1 both held valid, addr 0x5 and 0x10, IMEM_ARB_STARVE_EN defined, STARVE_LIMIT=4 -> four port 0 grants, then one port 1 grant; rsp1_data = 0xad6e0000; pattern repeats.
REQ-032 Same stimulus as REQ-031, macro undefined -> req1_ready never asserts over 100 cycles.
REQ-033 Grant port 1 at addr 0x24, then idle 3 cycles -> mem_addr stays 0x24; no rsp_valid after the first response cycle.
REQ-034 Grant port 0 in cycle N, rst asserted asynchronously mid-cycle N+1 -> rsp0_valid low immediately; mem_addr = 0; both ready low until rst deasserts.
REQ-035 Alternate req0 and req1 every cycle (never both) -> a grant every cycle; responses arrive in order on the correct port with 1-cycle latency.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Requester-side bundle for imem_arbiter: two read ports (CPU fetch, loader/debug).
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port instruction-memory arbiter, port 0 priority, 1-cycle read latency.
// Define IMEM_ARB_STARVE_EN to promote port 1 after STARVE_LIMIT consecutive losses.
module imem_arbiter #(
  parameter int unsigned ADDR_W       = 30,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  imem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_inst
);

  logic              promoted;
  logic              grant0;
  logic              grant1;
  logic              rsp_pend;
  logic              rsp_id;
  logic [ADDR_W-1:0] addr_hold;

  // Winner selection; nothing is granted while reset is asserted
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = bus.req0_valid & ~(promoted & bus.req1_valid);
      grant1 = bus.req1_valid & ~grant0;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Without a grant the memory keeps re-reading the last granted address
  always_comb begin
    mem_addr = addr_hold;
    if (grant0)      mem_addr = bus.req0_addr;
    else if (grant1) mem_addr = bus.req1_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pend  <= 1'b0;
      rsp_id    <= 1'b0;
      addr_hold <= '0;
    end else begin
      rsp_pend <= grant0 | grant1;
      rsp_id   <= grant1;
      if (grant0 | grant1) addr_hold <= mem_addr;
    end
  end

  assign bus.rsp0_valid = rsp_pend & ~rsp_id;
  assign bus.rsp1_valid = rsp_pend & rsp_id;
  assign bus.rsp0_data  = mem_inst;
  assign bus.rsp1_data  = mem_inst;

`ifdef IMEM_ARB_STARVE_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt;

  // Counts consecutive losses of a waiting port 1; saturates at LIMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (grant1 || !bus.req1_valid) begin
      starve_cnt <= 3'd0;
    end else if (grant0 && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign promoted = (starve_cnt == LIMIT);
`else
  logic unused_starve_limit;

  assign unused_starve_limit = ^3'(STARVE_LIMIT);
  assign promoted            = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised self-checking bench for imem_arbiter against a rule-level model.
module tb_imem_arbiter;
  localparam int unsigned AW  = 30;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_inst;
  logic [AW-1:0] mem_addr_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_inst (mem_inst)
  );

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    case (a)
      30'h0:   return 32'h3c081000;
      30'h1:   return 32'h350800b0;
      30'h2:   return 32'h3c091000;
      30'h10:  return 32'had6e0000;
      default: return (32'(a) * 32'h9e3779b1) ^ 32'h12345678;
    endcase
  endfunction

  // Instruction memory: registered address, data one cycle later
  always @(posedge clk) mem_addr_q <= mem_addr;
  assign mem_inst = data_of(mem_addr_q);

  // Reference model state
  int            loss;
  logic [AW-1:0] m_hold;
  logic [AW-1:0] m_prev_addr;
  bit            rsp_q[$];

  logic          e_g0, e_g1, e_rv0, e_rv1;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    loss        = 0;
    m_hold      = '0;
    m_prev_addr = '0;
    rsp_q.delete();
  endtask

  task automatic model_eval();
    bit p1_wins;
`ifdef IMEM_ARB_STARVE_EN
    p1_wins = bus.req1_valid && (!bus.req0_valid || loss >= int'(LIM));
`else
    p1_wins = bus.req1_valid && !bus.req0_valid;
`endif
    e_g1   = p1_wins;
    e_g0   = bus.req0_valid && !p1_wins;
    e_addr = e_g0 ? bus.req0_addr : (e_g1 ? bus.req1_addr : m_hold);
    e_rv0  = (rsp_q.size() > 0) && (rsp_q[0] == 1'b0);
    e_rv1  = (rsp_q.size() > 0) && (rsp_q[0] == 1'b1);
    e_data = data_of(m_prev_addr);
  endtask

  task automatic model_commit();
    rsp_q.delete();
    if (e_g0) rsp_q.push_back(1'b0);
    if (e_g1) rsp_q.push_back(1'b1);
    if (e_g0 || e_g1) m_hold = e_addr;
    m_prev_addr = e_addr;
    if (e_g1 || !bus.req1_valid) loss = 0;
    else if (e_g0 && loss < int'(LIM)) loss = loss + 1;
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0,
                       input logic v1, input logic [AW-1:0] a1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 30'h3;
    bus.req1_valid = 1'b1; bus.req1_addr = 30'h4;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
    end
    total++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_rsp_valid: got %b expected 00", {bus.rsp0_valid, bus.rsp1_valid});
    end
    total++;
    if (mem_addr !== '0) begin
      bad++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 30'h7, 1'b0, '0);
    total++;
    if (bus.req0_ready !== 1'b1 || e_g0 !== 1'b1) begin
      bad++; $display("FAIL first_grant: got %b expected 1", bus.req0_ready);
    end
    @(posedge clk); model_commit();
  endtask

  task automatic test_sequential();
    logic [DW-1:0] spec_words [3];
    spec_words[0] = 32'h3c081000;
    spec_words[1] = 32'h350800b0;
    spec_words[2] = 32'h3c091000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) drive(1'b1, AW'(i), 1'b0, '0);
      else       drive(1'b0, '0, 1'b0, '0);
      total++;
      if (bus.req0_ready !== e_g0) begin
        bad++; $display("FAIL seq_ready[%0d]: got %b expected %b", i, bus.req0_ready, e_g0);
      end
      total++;
      if (bus.rsp0_valid !== e_rv0) begin
        bad++; $display("FAIL seq_rsp_valid[%0d]: got %b expected %b", i, bus.rsp0_valid, e_rv0);
      end
      if (i >= 1 && i <= 3) begin
        total++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== spec_words[i-1]) begin
          bad++; $display("FAIL seq_data[%0d]: got %b/%h expected 1/%h", i, bus.rsp0_valid, bus.rsp0_data, spec_words[i-1]);
        end
      end
      @(posedge clk); model_commit();
    end
  endtask

  task automatic test_starvation();
    int n1 = 0;
    int exp_n1;
`ifdef IMEM_ARB_STARVE_EN
    exp_n1 = 100 / (int'(LIM) + 1);
`else
    exp_n1 = 0;
`endif
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive(1'b1, 30'h5, 1'b1, 30'h10);
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== {e_g0, e_g1}) begin
        bad++; $display("FAIL starve_ready[%0d]: got %b expected %b", i, {bus.req0_ready, bus.req1_ready}, {e_g0, e_g1});
      end
      if (bus.req1_ready === 1'b1) n1++;
      if (e_rv1) begin
        total++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'had6e0000) begin
          bad++; $display("FAIL starve_rsp1[%0d]: got %b/%h expected 1/ad6e0000", i, bus.rsp1_valid, bus.rsp1_data);
        end
      end
      @(posedge clk); model_commit();
    end
    total++;
    if (n1 !== exp_n1) begin
      bad++; $display("FAIL starve_port1_grants: got %0d expected %0d", n1, exp_n1);
    end
  endtask

  task automatic test_idle_hold();
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 30'h24);
    total++;
    if (bus.req1_ready !== 1'b1 || mem_addr !== 30'h24) begin
      bad++; $display("FAIL idle_grant: got %b/%h expected 1/24", bus.req1_ready, mem_addr);
    end
    @(posedge clk); model_commit();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, AW'($urandom), 1'b0, AW'($urandom));
      total++;
      if (mem_addr !== 30'h24 || {bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        bad++; $display("FAIL idle_hold[%0d]: got %h/%b expected 24/00", i, mem_addr, {bus.req0_ready, bus.req1_ready});
      end
      total++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== {1'b0, (i == 0)} || bus.rsp1_data !== data_of(30'h24)) begin
        bad++; $display("FAIL idle_rsp[%0d]: got %b/%h expected %b/%h", i, {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp1_data, {1'b0, (i == 0)}, data_of(30'h24));
      end
      @(posedge clk); model_commit();
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i[0] == 1'b0) drive(1'b1, AW'($urandom_range(0, 255)), 1'b0, '0);
      else              drive(1'b0, '0, 1'b1, AW'($urandom_range(0, 255)));
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== {e_g0, e_g1} || (e_g0 ^ e_g1) !== 1'b1 || mem_addr !== e_addr) begin
        bad++; $display("FAIL alt_grant[%0d]: got %b/%h expected %b/%h", i, {bus.req0_ready, bus.req1_ready}, mem_addr, {e_g0, e_g1}, e_addr);
      end
      if (i > 0) begin
        total++;
        if ({bus.rsp0_valid, bus.rsp1_valid} !== {e_rv0, e_rv1} || bus.rsp0_data !== e_data) begin
          bad++; $display("FAIL alt_rsp[%0d]: got %b/%h expected %b/%h", i, {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp0_data, {e_rv0, e_rv1}, e_data);
        end
      end
      @(posedge clk); model_commit();
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 30'h33, 1'b0, '0);
    @(posedge clk); model_commit();
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0);
    total++;
    if (bus.rsp0_valid !== 1'b1) begin
      bad++; $display("FAIL arst_before: got %b expected 1", bus.rsp0_valid);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00 || mem_addr !== '0) begin
      bad++; $display("FAIL arst_immediate: got %b/%h expected 00/0", {bus.rsp0_valid, bus.rsp1_valid}, mem_addr);
    end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00 || {bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
      bad++; $display("FAIL arst_hold: got %b/%b expected 00/00", {bus.req0_ready, bus.req1_ready}, {bus.rsp0_valid, bus.rsp1_valid});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    total++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00 || mem_addr !== '0) begin
      bad++; $display("FAIL arst_discard: got %b/%h expected 00/0", {bus.rsp0_valid, bus.rsp1_valid}, mem_addr);
    end
    @(posedge clk); model_commit();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 63)),
            ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 63)));
      total++;
      if ({bus.req0_ready, bus.req1_ready} !== {e_g0, e_g1} || mem_addr !== e_addr) begin
        bad++; $display("FAIL rnd_grant[%0d]: got %b/%h expected %b/%h", i, {bus.req0_ready, bus.req1_ready}, mem_addr, {e_g0, e_g1}, e_addr);
      end
      total++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== {e_rv0, e_rv1} ||
          bus.rsp0_data !== e_data || bus.rsp1_data !== e_data) begin
        bad++; $display("FAIL rnd_rsp[%0d]: got %b/%h expected %b/%h", i, {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp0_data, {e_rv0, e_rv1}, e_data);
      end
      @(posedge clk); model_commit();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_starvation();
    test_idle_hold();
    test_alternate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
